// File: rtl/lms_pkg.sv
// rtl/lms_pkg.sv - shared state encoding, widths and saturating shift helper for the LMS error monitor
package lms_pkg;

    localparam int LMS_DATA_WIDTH = 12;
    localparam int LMS_MSE_W      = 2 * LMS_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_ACQUIRE   = 2'b00,
        ST_CONVERGED = 2'b01,
        ST_DIVERGED  = 2'b10
    } lms_state_e;

    // Left shift by two, clamped to all-ones of a w-bit field (2 < w < 64).
    function automatic logic [63:0] lms_sat_shl2(input logic [63:0] x, input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if ((x >> (w - 2)) != 64'd0) begin
            return mask;
        end
        return (x << 2) & mask;
    endfunction

endpackage

// File: rtl/lms_sq_acc.sv
// rtl/lms_sq_acc.sv - squares error samples and averages them over power-of-two windows
module lms_sq_acc #(
    parameter int DATA_WIDTH = 12,
    parameter int WIN_LOG2   = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clear_in,
    input  logic signed [DATA_WIDTH-1:0] err_in,
    input  logic                         err_valid_in,
    output logic [2*DATA_WIDTH-1:0]      mse_out,
    output logic                         mse_valid_out
);

    localparam int MSE_W = 2 * DATA_WIDTH;
    localparam int ACC_W = MSE_W + WIN_LOG2;

    logic signed [MSE_W-1:0] prod;
    logic [MSE_W-1:0]        sq_d, sq_q;
    logic                    sq_vld_d, sq_vld_q;
    logic [ACC_W-1:0]        acc_d, acc_q, sum;
    logic [WIN_LOG2-1:0]     cnt_d, cnt_q;
    logic [MSE_W-1:0]        mse_d, mse_q;
    logic                    mse_vld_d, mse_vld_q;

    assign prod = err_in * err_in;
    assign sum  = acc_q + ACC_W'(sq_q);

    always_comb begin
        sq_d      = sq_q;
        sq_vld_d  = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mse_d     = mse_q;
        mse_vld_d = 1'b0;

        if (err_valid_in) begin
            sq_d     = $unsigned(prod);
            sq_vld_d = 1'b1;
        end

        if (sq_vld_q) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                mse_d     = MSE_W'(sum >> WIN_LOG2);
                acc_d     = '0;
                mse_vld_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end

        // Restart drops both the incoming sample and the one already in stage 1.
        if (clear_in) begin
            sq_vld_d  = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            mse_d     = mse_q;
            mse_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sq_q      <= '0;
            sq_vld_q  <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mse_q     <= '0;
            mse_vld_q <= 1'b0;
        end else begin
            sq_q      <= sq_d;
            sq_vld_q  <= sq_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mse_q     <= mse_d;
            mse_vld_q <= mse_vld_d;
        end
    end

    assign mse_out       = mse_q;
    assign mse_valid_out = mse_vld_q;

endmodule

// File: rtl/lms_err_monitor.sv
// rtl/lms_err_monitor.sv - LMS convergence monitor: windowed MSE plus hysteretic acquire/converged/diverged FSM
module lms_err_monitor
    import lms_pkg::*;
#(
    parameter int DATA_WIDTH = LMS_DATA_WIDTH,
    parameter int WIN_LOG2   = 6,
    parameter int HOLD       = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic signed [DATA_WIDTH-1:0] err_in,
    input  logic                         err_valid_in,
    input  logic                         clear_in,
    input  logic [2*DATA_WIDTH-1:0]      thresh_in,
    output logic [2*DATA_WIDTH-1:0]      mse_out,
    output logic                         mse_valid_out,
    output logic [1:0]                   state_out,
    output logic                         converged_out,
    output logic                         diverged_out
);

    localparam int MSE_W = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(HOLD + 1);

    logic [MSE_W-1:0] mse;
    logic             mse_vld;
    logic [MSE_W-1:0] thr4;
    lms_state_e       state_q;
    logic [CNT_W-1:0] good_cnt_q, bad_cnt_q;

    lms_sq_acc #(
        .DATA_WIDTH(DATA_WIDTH),
        .WIN_LOG2  (WIN_LOG2)
    ) u_sq_acc (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (clear_in),
        .err_in       (err_in),
        .err_valid_in (err_valid_in),
        .mse_out      (mse),
        .mse_valid_out(mse_vld)
    );

    assign thr4 = MSE_W'(lms_sat_shl2(64'(thresh_in), MSE_W));

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            state_q    <= ST_ACQUIRE;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else if (mse_vld) begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (mse <= thresh_in) begin
                        if (good_cnt_q == CNT_W'(HOLD - 1)) begin
                            state_q    <= ST_CONVERGED;
                            good_cnt_q <= '0;
                            bad_cnt_q  <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 1'b1;
                        end
                    end else begin
                        good_cnt_q <= '0;
                    end
                end
                ST_CONVERGED: begin
                    if (mse > thr4) begin
                        if (bad_cnt_q == CNT_W'(HOLD - 1)) begin
                            state_q   <= ST_DIVERGED;
                            bad_cnt_q <= '0;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 1'b1;
                        end
                    end else begin
                        bad_cnt_q <= '0;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign mse_out       = mse;
    assign mse_valid_out = mse_vld;
    assign state_out     = state_q;
    assign converged_out = (state_q == ST_CONVERGED);
    assign diverged_out  = (state_q == ST_DIVERGED);

endmodule

// File: doc/lms_err_monitor.md
# lms_err_monitor

Convergence monitor sitting directly downstream of the LMS filter: consumes the filter's per-sample error, squares it, and averages it over fixed power-of-two windows to produce a mean-square-error (MSE) estimate. A small state machine compares each window's MSE against a programmable threshold, with consecutive-window hysteresis, and reports whether the adaptive filter is acquiring, converged, or diverged. Its outputs feed status registers and any supervisor that re-initialises the filter.

## Interface
- DATA_WIDTH, 12: width of the signed two's-complement error sample; matches the filter's data width.
- WIN_LOG2, 6: log2 of the averaging window length; the window is 2^WIN_LOG2 accepted samples.
- HOLD, 4: number of consecutive qualifying windows required for a state change.
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- err_in  input  DATA_WIDTH  signed error sample from the filter.
- err_valid_in  input  1  err_in is valid this cycle; there is no backpressure, so the block always accepts.
- clear_in  input  1  synchronous restart: flushes the pipeline, accumulator and counters, and sets state to ACQUIRE.
- thresh_in  input  2*DATA_WIDTH  unsigned MSE convergence threshold; sampled at the window compare.
- mse_out  output  2*DATA_WIDTH  unsigned MSE of the last completed window; held between windows.
- mse_valid_out  output  1  one-cycle pulse when mse_out updates.
- state_out  output  2  current state: ACQUIRE=00, CONVERGED=01, DIVERGED=10; 11 is unused.
- converged_out  output  1  high when state_out is CONVERGED.
- diverged_out  output  1  high when state_out is DIVERGED.

## Operation
- Stage 1: on err_valid_in, register sq = err_in*err_in as a signed multiply. The unsigned result occupies 2*DATA_WIDTH bits; the maximum is 2^(2*DATA_WIDTH-2) at err_in = -2^(DATA_WIDTH-1).
- Stage 2: a valid sq adds into the accumulator, which is 2*DATA_WIDTH+WIN_LOG2 bits wide and cannot overflow.
- A WIN_LOG2-bit sample counter advances only on valid stage-2 samples. Idle cycles and gaps in err_valid_in do not count and do not disturb the accumulator.
- On the sample that wraps the counter from all-ones to zero:
  - mse_out <= (acc + sq) >> WIN_LOG2, truncating.
  - The accumulator restarts at zero.
  - mse_valid_out pulses.
- Each mse_valid_out event runs one FSM evaluation. thr4 = thresh_in << 2, saturating to all-ones of 2*DATA_WIDTH.
  - ACQUIRE: if mse <= thresh_in, good_cnt++; otherwise good_cnt = 0. When good_cnt reaches HOLD, go to CONVERGED and clear both counters.
  - CONVERGED: if mse > thr4, bad_cnt++; otherwise bad_cnt = 0. When bad_cnt reaches HOLD, go to DIVERGED.
  - DIVERGED: sticky. MSE keeps updating. The only exits are clear_in and rst_in.
- thr4 gives a 4x hysteresis band, so a converged filter with mild noise does not chatter.
- clear_in has priority over everything else:
  - A sample presented in the same cycle is discarded, and the stage-1 valid is dropped.
  - Counters, accumulator, good_cnt and bad_cnt are zeroed; state goes to ACQUIRE.
  - mse_out holds its value, and no mse_valid_out pulse is generated.
- rst_in zeroes everything, including mse_out.

## Timing
- Reset values: mse_out=0, mse_valid_out=0, state_out=00, converged_out=0, diverged_out=0.
- Latency: if the last sample of a window is accepted at cycle N, mse_out and mse_valid_out appear at N+2, and state_out reflects that window at N+3.
- Throughput: one sample per cycle, sustained indefinitely.
- Back-to-back windows: a new window's first sample may arrive the cycle after the previous window's last sample, with no bubble.
- rst_in or clear_in asserted mid-window: the partial window is discarded, and the next mse_valid_out comes only after 2^WIN_LOG2 new samples.
- thresh_in may change at any time and takes effect at the next evaluation.

## Structure
- Shared package lms_pkg holds:
  - the state encoding localparams (ST_ACQUIRE, ST_CONVERGED, ST_DIVERGED);
  - the MSE width constant 2*DATA_WIDTH;
  - the saturating shift-left helper.
- One sub-module, lms_sq_acc, holds the square, windowed accumulate and counter (stage 1 and stage 2) and emits mse plus its valid pulse. The top level holds the FSM and the hysteresis counters.
- Target size is about 200 RTL lines in total.

## Test plan
All scenarios use DATA_WIDTH=12, WIN_LOG2=2 and HOLD=2.
- Reset: assert rst_in for 3 cycles -> all outputs 0 and state_out=00. Do not assert err_valid_in -> mse_valid_out never pulses.
- Constant error: err_in=10 on 4 back-to-back valid cycles -> mse_out=100, mse_valid_out pulses once, exactly 2 cycles after the 4th sample.
- Extreme value: err_in=-2048 for 4 samples -> mse_out=4194304 (0x400000), with no wrap. Then err_in=2047 for 4 samples -> mse_out=4190209.
- Convergence and divergence:
  - thresh_in=100, err_in=5 for 8 samples -> two windows with MSE 25, converged_out=1 after the 2nd.
  - Then err_in=30 for 8 samples (MSE 900 > 400) -> diverged_out=1.
  - Then err_in=0 -> stays DIVERGED.
  - clear_in pulse -> state_out=00.
- Hysteresis: thresh_in=100, with windows alternating MSE 25 and MSE 144 for 8 windows -> never leaves ACQUIRE.
- Gaps and clear: 4 samples of err_in=3 with random err_valid_in gaps -> mse_out=9, the same as the contiguous case. Then clear_in in the same cycle as the 3rd sample of the next window -> that sample is dropped, and no pulse occurs until 4 further samples arrive.
